dpe_wg_tag_splitter: RTL
========================

# dpe_wg_tag_splitter

Sits directly downstream of the WireGuard disassembler in the DPE receive path. On WireGuard packets it strips the trailing 16-byte Poly1305 tag from the payload stream. It emits the ciphertext-only AXI-Stream toward the ChaCha20 decrypt stage and presents the tag as a sideband on the last ciphertext beat. Non-WireGuard packets pass through byte-for-byte.

## Interface
- TDATA_WIDTH, 128, stream data width; fixed, 16 byte lanes (lane i = tdata[8i+7:8i], packet byte order lane 0 first).
- TUSER_WIDTH, 128, sideband width: [127:96] receiver index, [95:32] counter, [5] WG flag, [4:0] ingress user bits.
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- inp  dpe_if.s_axis  128/16/1/128  disassembled stream; tkeep all-ones on non-last beats, contiguous from lane 0 on last beat.
- outp  dpe_if.m_axis  128/16/1/128  ciphertext stream; tuser forwarded unchanged from the held beat.
- outp_tag  out  128  Poly1305 tag, tag byte 0 at [7:0]; qualified by outp.tvalid & outp.tlast & outp.tuser[5].
- outp_tag_err  out  1  WG packet shorter than 16 bytes; same qualifier.
- err_cnt  out  16  saturating count of outp_tag_err packets.
- fcr_idle  out  1  hold register empty and outp.tvalid low.

## Operation
- FSM states: EMPTY (hold register H invalid) and HOLD (H holds one accepted beat).
- EMPTY, accept B with !B.tlast -> load H, go HOLD, emit nothing.
- EMPTY, accept B with B.tlast (single-beat packet):
  - non-WG: emit B unchanged.
  - WG with K=16, where K = number of set tkeep bits of B: emit tkeep=0, tlast=1, tdata=0, outp_tag=B.tdata.
  - WG with K<16: emit tkeep=0, tlast=1, outp_tag=0, outp_tag_err=1, increment err_cnt.
  - Stay EMPTY in all three cases.
- HOLD, accept B with !B.tlast -> emit H unchanged, load B, stay HOLD.
- HOLD, accept B with B.tlast:
  - non-WG: emit H, load B, stay HOLD; B is flushed on the next cycle with outp.tlast=1 and no input consumed.
  - WG: emit H with tkeep=(1<<K)-1 (all-ones when K=16), tlast=1, outp_tag = {B.tdata[8K-1:0], H.tdata[127:8K]} (K=16 -> B.tdata). Do not store B; go EMPTY.
- The WG flag is taken from the tuser[5] bit of the beat carrying tlast.
- Emitted beats always carry the tuser of the beat being emitted.
- outp_tag and outp_tag_err are 0 on every beat that does not meet their qualifier.
- err_cnt saturates at 16'hFFFF.

## Timing
- All emitted beats pass through a one-deep register slice (axis_register); muxed-to-outp latency is 1 cycle.
- inp.tready = slice s_axis_tready, except in EMPTY while loading a non-last beat, where it is 1.
- A non-WG flush cycle deasserts inp.tready.
- Steady-state throughput is 1 beat/cycle. Only a non-WG last beat arriving in HOLD adds 1 bubble.
- Beat n appears at outp 1 cycle after beat n+1 is accepted.
- A WG last beat produces its output 1 cycle after acceptance.
- outp stall: H and the slice keep their contents; nothing is dropped or duplicated; all outputs stay stable while tvalid & !tready.
- Simultaneous input accept and output drain in the same cycle is supported with no bubble.
- Reset values: outp.tvalid=0, outp.tlast=0, outp.tkeep=0, outp.tdata=0, outp.tuser=0, outp_tag=0, outp_tag_err=0, err_cnt=0, fcr_idle=1, state EMPTY.
- Reset mid-packet discards H and the slice contents. The next accepted beat starts a new packet.

## Structure
- Shared package dpe_wg_pkg holds:
  - TUSER field positions: WG flag 5, receiver [127:96], counter [95:32].
  - WG_TAG_BYTES=16.
  - The state_t enum {EMPTY, HOLD}; the non-WG flush is an internal flag.
- Sub-module: axis_register, with USER_WIDTH=257 carrying {tag_err, tag, tuser}; it is split back at outp.
- Keep-count function: tkeep -> K (1..16).

## Test plan
- WG 3-beat packet, last tkeep=16'h00FF (K=8) -> 2 outp beats; beat 2 tkeep=16'h00FF, tlast=1; outp_tag = {last[63:0], beat2[127:64]}.
- WG 2-beat packet, last tkeep=16'hFFFF -> 1 beat, tkeep all-ones, tlast=1; outp_tag = beat2 data.
- WG single beat, tkeep=16'hFFFF (keepalive) -> tkeep=0, tlast=1, outp_tag = input data.
- WG single beat, tkeep=16'h0FFF -> outp_tag_err=1, err_cnt 0->1.
- Non-WG 4-beat packet, last tkeep=16'h0007 -> identical 4 beats out.
- Random outp.tready at 30%, 200 mixed packets -> scoreboard match and no beat loss.
- Reset asserted while in HOLD -> outp.tvalid=0 next cycle, fcr_idle=1.

Source files
------------

// File: rtl/dpe_wg_pkg.sv
// Shared definitions for the WireGuard tag splitter.
// Holds the stream widths, the tuser field layout, the tag size, the splitter
// state type and the tkeep byte-count helper.
package dpe_wg_pkg;

    localparam int unsigned TDATA_WIDTH  = 128;
    localparam int unsigned TKEEP_WIDTH  = TDATA_WIDTH / 8;
    localparam int unsigned TUSER_WIDTH  = 128;
    localparam int unsigned WG_TAG_BYTES = 16;

    // tuser[5] marks a WireGuard packet
    localparam int unsigned TUSER_WG_BIT = 5;

    // Slice sideband: {tag_err, tag, tuser}
    localparam int unsigned SLICE_USER_WIDTH = 1 + TDATA_WIDTH + TUSER_WIDTH;

    // tuser layout: [127:96] receiver, [95:32] counter, [5] WG, [4:0] ingress
    typedef struct packed {
        logic [31:0] receiver;
        logic [63:0] counter;
        logic [25:0] rsvd;
        logic        wg;
        logic [4:0]  ingress;
    } tuser_t;

    typedef enum logic {
        EMPTY,
        HOLD
    } state_t;

    // Number of set tkeep bits (1..16 for a valid last beat)
    function automatic logic [4:0] keep_count(input logic [TKEEP_WIDTH-1:0] keep);
        logic [4:0] cnt;
        cnt = '0;
        for (int i = 0; i < int'(TKEEP_WIDTH); i++) begin
            cnt = cnt + 5'(keep[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/axis_register.sv
// One-deep AXI-Stream register slice.
// Ports: clk/rst (sync, active-high); s_axis_* upstream beat in;
// m_axis_* registered beat out. Accepts a new beat whenever empty or being
// drained in the same cycle, so it sustains one beat per cycle.
module axis_register #(
    parameter int unsigned DATA_WIDTH = 128,
    parameter int unsigned KEEP_WIDTH = 16,
    parameter int unsigned USER_WIDTH = 257
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_axis_tvalid_i,
    output logic                  s_axis_tready_o,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata_i,
    input  logic [KEEP_WIDTH-1:0] s_axis_tkeep_i,
    input  logic                  s_axis_tlast_i,
    input  logic [USER_WIDTH-1:0] s_axis_tuser_i,
    output logic                  m_axis_tvalid_o,
    input  logic                  m_axis_tready_i,
    output logic [DATA_WIDTH-1:0] m_axis_tdata_o,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep_o,
    output logic                  m_axis_tlast_o,
    output logic [USER_WIDTH-1:0] m_axis_tuser_o
);

    logic                  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [KEEP_WIDTH-1:0] keep_q, keep_d;
    logic                  last_q, last_d;
    logic [USER_WIDTH-1:0] user_q, user_d;

    assign s_axis_tready_o = !valid_q || m_axis_tready_i;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        keep_d  = keep_q;
        last_d  = last_q;
        user_d  = user_q;
        if (s_axis_tvalid_i && s_axis_tready_o) begin
            valid_d = 1'b1;
            data_d  = s_axis_tdata_i;
            keep_d  = s_axis_tkeep_i;
            last_d  = s_axis_tlast_i;
            user_d  = s_axis_tuser_i;
        end else if (m_axis_tready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            keep_q  <= '0;
            last_q  <= 1'b0;
            user_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            keep_q  <= keep_d;
            last_q  <= last_d;
            user_q  <= user_d;
        end
    end

    assign m_axis_tvalid_o = valid_q;
    assign m_axis_tdata_o  = data_q;
    assign m_axis_tkeep_o  = keep_q;
    assign m_axis_tlast_o  = last_q;
    assign m_axis_tuser_o  = user_q;

endmodule

// File: rtl/dpe_wg_tag_splitter.sv
// Strips the trailing 16-byte Poly1305 tag from WireGuard packets and presents
// it as a sideband on the last ciphertext beat; other packets pass unchanged.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   inp_*               disassembled input stream (tvalid/tready/tdata/tkeep/tlast/tuser)
//   outp_*              ciphertext output stream, registered through axis_register
//   outp_tag_o          tag, valid on outp tvalid & tlast & tuser[5]
//   outp_tag_err_o      WG packet shorter than the tag, same qualifier
//   err_cnt_o           saturating count of tag_err packets
//   fcr_idle_o          hold register empty and output idle
// One beat is held back (H) so the tag bytes straddling the last two beats can
// be gathered before the final ciphertext beat is emitted.
module dpe_wg_tag_splitter
    import dpe_wg_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   inp_tvalid_i,
    output logic                   inp_tready_o,
    input  logic [TDATA_WIDTH-1:0] inp_tdata_i,
    input  logic [TKEEP_WIDTH-1:0] inp_tkeep_i,
    input  logic                   inp_tlast_i,
    input  logic [TUSER_WIDTH-1:0] inp_tuser_i,
    output logic                   outp_tvalid_o,
    input  logic                   outp_tready_i,
    output logic [TDATA_WIDTH-1:0] outp_tdata_o,
    output logic [TKEEP_WIDTH-1:0] outp_tkeep_o,
    output logic                   outp_tlast_o,
    output logic [TUSER_WIDTH-1:0] outp_tuser_o,
    output logic [TDATA_WIDTH-1:0] outp_tag_o,
    output logic                   outp_tag_err_o,
    output logic [15:0]            err_cnt_o,
    output logic                   fcr_idle_o
);

    state_t                 state_q, state_d;
    logic                   flush_q, flush_d;   // H holds a non-WG last beat
    logic [TDATA_WIDTH-1:0] h_data_q, h_data_d;
    logic [TKEEP_WIDTH-1:0] h_keep_q, h_keep_d;
    logic [TUSER_WIDTH-1:0] h_user_q, h_user_d;
    logic [15:0]            err_cnt_q, err_cnt_d;

    logic                        slice_ready;
    logic                        s_valid;
    logic [TDATA_WIDTH-1:0]      s_data;
    logic [TKEEP_WIDTH-1:0]      s_keep;
    logic                        s_last;
    logic [TUSER_WIDTH-1:0]      s_user;
    logic [TDATA_WIDTH-1:0]      s_tag;
    logic                        s_err;
    logic [SLICE_USER_WIDTH-1:0] m_side;

    logic [4:0]             k;
    logic                   in_wg;
    logic [TKEEP_WIDTH-1:0] hold_mask;
    logic [TDATA_WIDTH-1:0] tag_split;

    assign k         = keep_count(inp_tkeep_i);
    assign in_wg     = inp_tuser_i[TUSER_WG_BIT];
    assign hold_mask = 16'((17'd1 << k) - 17'd1);
    // Tag = bytes K..K+15 of {B, H}: the tail of H followed by the K bytes of B
    assign tag_split = 128'({inp_tdata_i, h_data_q} >> {k, 3'b000});

    always_comb begin
        state_d      = state_q;
        flush_d      = flush_q;
        h_data_d     = h_data_q;
        h_keep_d     = h_keep_q;
        h_user_d     = h_user_q;
        err_cnt_d    = err_cnt_q;
        inp_tready_o = slice_ready;
        s_valid      = 1'b0;
        s_data       = h_data_q;
        s_keep       = h_keep_q;
        s_last       = 1'b0;
        s_user       = h_user_q;
        s_tag        = '0;
        s_err        = 1'b0;

        if (flush_q) begin
            inp_tready_o = 1'b0;
            s_valid      = 1'b1;
            s_last       = 1'b1;
            if (slice_ready) begin
                flush_d = 1'b0;
                state_d = EMPTY;
            end
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (!inp_tlast_i) begin
                        // Loading H emits nothing, so the slice is not involved
                        inp_tready_o = 1'b1;
                        if (inp_tvalid_i) begin
                            h_data_d = inp_tdata_i;
                            h_keep_d = inp_tkeep_i;
                            h_user_d = inp_tuser_i;
                            state_d  = HOLD;
                        end
                    end else if (inp_tvalid_i) begin
                        s_valid = 1'b1;
                        s_data  = inp_tdata_i;
                        s_keep  = inp_tkeep_i;
                        s_last  = 1'b1;
                        s_user  = inp_tuser_i;
                        if (in_wg) begin
                            s_data = '0;
                            s_keep = '0;
                            if (k == 5'(WG_TAG_BYTES)) begin
                                s_tag = inp_tdata_i;
                            end else begin
                                s_err = 1'b1;
                                if (slice_ready && (err_cnt_q != 16'hFFFF)) begin
                                    err_cnt_d = err_cnt_q + 16'd1;
                                end
                            end
                        end
                    end
                end
                HOLD: begin
                    if (inp_tvalid_i) begin
                        s_valid = 1'b1;
                        if (inp_tlast_i && in_wg) begin
                            s_keep = hold_mask;
                            s_last = 1'b1;
                            s_tag  = tag_split;
                        end
                        if (slice_ready) begin
                            if (inp_tlast_i && in_wg) begin
                                state_d = EMPTY;
                            end else begin
                                h_data_d = inp_tdata_i;
                                h_keep_d = inp_tkeep_i;
                                h_user_d = inp_tuser_i;
                                flush_d  = inp_tlast_i;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= EMPTY;
            flush_q   <= 1'b0;
            h_data_q  <= '0;
            h_keep_q  <= '0;
            h_user_q  <= '0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            flush_q   <= flush_d;
            h_data_q  <= h_data_d;
            h_keep_q  <= h_keep_d;
            h_user_q  <= h_user_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    axis_register #(
        .DATA_WIDTH(TDATA_WIDTH),
        .KEEP_WIDTH(TKEEP_WIDTH),
        .USER_WIDTH(SLICE_USER_WIDTH)
    ) u_slice (
        .clk            (clk),
        .rst            (rst),
        .s_axis_tvalid_i(s_valid),
        .s_axis_tready_o(slice_ready),
        .s_axis_tdata_i (s_data),
        .s_axis_tkeep_i (s_keep),
        .s_axis_tlast_i (s_last),
        .s_axis_tuser_i ({s_err, s_tag, s_user}),
        .m_axis_tvalid_o(outp_tvalid_o),
        .m_axis_tready_i(outp_tready_i),
        .m_axis_tdata_o (outp_tdata_o),
        .m_axis_tkeep_o (outp_tkeep_o),
        .m_axis_tlast_o (outp_tlast_o),
        .m_axis_tuser_o (m_side)
    );

    assign outp_tuser_o   = m_side[TUSER_WIDTH-1:0];
    assign outp_tag_o     = m_side[TUSER_WIDTH +: TDATA_WIDTH];
    assign outp_tag_err_o = m_side[SLICE_USER_WIDTH-1];
    assign err_cnt_o      = err_cnt_q;
    assign fcr_idle_o     = (state_q == EMPTY) && !outp_tvalid_o;

endmodule
